// File: rtl/data_path_v1_pkg.sv
// Shared widths and ALU opcode encodings for the data_path_v1 slice.
// Imported by the register file and the top level.
package data_path_v1_pkg;

    localparam int DATA_W    = 64;
    localparam int SEL_W     = 5;
    localparam int NUM_REGS  = 32;
    localparam int NUM_LOW   = 8;
    localparam int LOW_W     = 16;
    localparam int RAM_DEPTH = 256;
    localparam int RAM_AW    = 8;
    localparam int SHAMT_W   = 6;

    localparam logic [SEL_W-1:0] ZERO_REG = SEL_W'(NUM_REGS - 1);

    // FS[4:2]; FS[1] inverts A, FS[0] inverts B. 3'b111 also passes A.
    typedef enum logic [2:0] {
        ALU_AND  = 3'b000,
        ALU_XOR  = 3'b001,
        ALU_ADD  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_SHL  = 3'b100,
        ALU_SHR  = 3'b101,
        ALU_PASS = 3'b110
    } alu_op_e;

endpackage

// File: rtl/reg_file_32x64.sv
// 32 x 64-bit register file: two combinational read ports, one write port.
// X31 is hardwired to zero and has no storage.
module reg_file_32x64
    import data_path_v1_pkg::*;
(
    input  logic                          clock,
    input  logic                          reset_reg,
    input  logic                          w_reg,
    input  logic [SEL_W-1:0]              DA,
    input  logic [SEL_W-1:0]              SA,
    input  logic [SEL_W-1:0]              SB,
    input  logic [DATA_W-1:0]             w_data,
    output logic [DATA_W-1:0]             a_data,
    output logic [DATA_W-1:0]             b_data,
    output logic [NUM_LOW-1:0][LOW_W-1:0] low_regs
);

    logic [DATA_W-1:0] regs [NUM_REGS-1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset_reg) begin
            for (int i = 0; i < NUM_REGS - 1; i++) begin
                regs[i] <= '0;
            end
        end else if (w_reg && (DA != ZERO_REG)) begin
            regs[DA] <= w_data;
        end
    end

    assign a_data = (SA == ZERO_REG) ? '0 : regs[SA];
    assign b_data = (SB == ZERO_REG) ? '0 : regs[SB];

    always_comb begin
        for (int i = 0; i < NUM_LOW; i++) begin
            low_regs[i] = regs[i][LOW_W-1:0];
        end
    end

endmodule

// File: rtl/data_path_v1.sv
// Datapath top: register file, ALU, address adder, 256-word RAM and the
// tri-state drivers sharing data_bus. Driver exclusivity is left to the user.
module data_path_v1
    import data_path_v1_pkg::*;
(
    output logic [LOW_W-1:0]  r0,
    output logic [LOW_W-1:0]  r1,
    output logic [LOW_W-1:0]  r2,
    output logic [LOW_W-1:0]  r3,
    output logic [LOW_W-1:0]  r4,
    output logic [LOW_W-1:0]  r5,
    output logic [LOW_W-1:0]  r6,
    output logic [LOW_W-1:0]  r7,
    inout  wire  [DATA_W-1:0] data_bus,
    input  logic [DATA_W-1:0] k,
    input  logic [SEL_W-1:0]  FS,
    input  logic              B_Sel,
    input  logic              EN_B,
    input  logic              EN_ALU,
    input  logic              EN_ADDR_ALU,
    input  logic              ram_cs,
    input  logic              ram_write_en,
    input  logic              ram_read_en,
    input  logic              w_reg,
    input  logic              reset_reg,
    input  logic              clock,
    input  logic [SEL_W-1:0]  SA,
    input  logic [SEL_W-1:0]  SB,
    input  logic [SEL_W-1:0]  DA,
    input  logic              C0
);

    logic [DATA_W-1:0]             a_data;
    logic [DATA_W-1:0]             b_data;
    logic [NUM_LOW-1:0][LOW_W-1:0] low_regs;

    reg_file_32x64 u_reg_file (
        .clock     (clock),
        .reset_reg (reset_reg),
        .w_reg     (w_reg),
        .DA        (DA),
        .SA        (SA),
        .SB        (SB),
        .w_data    (data_bus),
        .a_data    (a_data),
        .b_data    (b_data),
        .low_regs  (low_regs)
    );

    assign r0 = low_regs[0];
    assign r1 = low_regs[1];
    assign r2 = low_regs[2];
    assign r3 = low_regs[3];
    assign r4 = low_regs[4];
    assign r5 = low_regs[5];
    assign r6 = low_regs[6];
    assign r7 = low_regs[7];

    logic [DATA_W-1:0]  a_op;
    logic [DATA_W-1:0]  b_op;
    logic [DATA_W-1:0]  alu_y;
    logic [SHAMT_W-1:0] shamt;

    assign a_op  = FS[1] ? ~a_data : a_data;
    assign b_op  = FS[0] ? ~(B_Sel ? k : b_data) : (B_Sel ? k : b_data);
    assign shamt = b_op[SHAMT_W-1:0];

    // NOTE: assigning a default first keeps always_comb latch-free for any
    // opcode the case does not list.
    always_comb begin
        alu_y = a_op;
        case (FS[4:2])
            ALU_AND:  alu_y = a_op & b_op;
            ALU_XOR:  alu_y = a_op ^ b_op;
            ALU_ADD:  alu_y = a_op + b_op + DATA_W'(C0);
            ALU_OR:   alu_y = a_op | b_op;
            ALU_SHL:  alu_y = a_op << shamt;
            ALU_SHR:  alu_y = a_op >> shamt;
            default:  alu_y = a_op;
        endcase
    end

    logic [DATA_W-1:0] addr_sum;
    logic [RAM_AW-1:0] ram_addr;

    assign addr_sum = a_data + k;
    assign ram_addr = addr_sum[RAM_AW-1:0];

    logic [DATA_W-1:0] ram [RAM_DEPTH];

    // NOTE: RAM has no reset; contents survive reset_reg and stay X until
    // written, which keeps it mappable onto block memory.
    always_ff @(posedge clock) begin
        if (ram_cs && ram_write_en) begin
            ram[ram_addr] <= data_bus;
        end
    end

    assign data_bus = EN_B                    ? b_data         : 'z;
    assign data_bus = EN_ALU                  ? alu_y          : 'z;
    assign data_bus = EN_ADDR_ALU             ? addr_sum       : 'z;
    assign data_bus = (ram_cs && ram_read_en) ? ram[ram_addr]  : 'z;

endmodule

// File: tb/tb_data_path_v1.sv
// Directed bench for data_path_v1: scripted register/RAM sequences plus a
// table of combinational ALU and address-adder vectors.
module tb_data_path_v1;

    logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7;
    wire  [63:0] data_bus;
    logic [63:0] k;
    logic [4:0]  FS, SA, SB, DA;
    logic        B_Sel, EN_B, EN_ALU, EN_ADDR_ALU;
    logic        ram_cs, ram_write_en, ram_read_en;
    logic        w_reg, reset_reg, clock, C0;

    logic        tb_en;
    logic [63:0] tb_drive;
    assign data_bus = tb_en ? tb_drive : 'z;

    logic [15:0] rr [8];
    assign rr[0] = r0;
    assign rr[1] = r1;
    assign rr[2] = r2;
    assign rr[3] = r3;
    assign rr[4] = r4;
    assign rr[5] = r5;
    assign rr[6] = r6;
    assign rr[7] = r7;

    data_path_v1 dut (
        .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
        .data_bus(data_bus), .k(k), .FS(FS), .B_Sel(B_Sel),
        .EN_B(EN_B), .EN_ALU(EN_ALU), .EN_ADDR_ALU(EN_ADDR_ALU),
        .ram_cs(ram_cs), .ram_write_en(ram_write_en), .ram_read_en(ram_read_en),
        .w_reg(w_reg), .reset_reg(reset_reg), .clock(clock),
        .SA(SA), .SB(SB), .DA(DA), .C0(C0)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        EN_B = 0; EN_ALU = 0; EN_ADDR_ALU = 0;
        ram_cs = 0; ram_write_en = 0; ram_read_en = 0;
        w_reg = 0; B_Sel = 1; C0 = 0; FS = 5'b00000;
        SA = 5'd0; SB = 5'd0; DA = 5'd0; k = '0;
        tb_en = 0; tb_drive = '0;
    endtask

    typedef struct {
        string       name;
        logic        en_b, en_alu, en_addr, b_sel, c0;
        logic [4:0]  fs, sa, sb;
        logic [63:0] k;
        logic [63:0] exp_bus;
    } vec_t;

    vec_t vecs[13];

    initial begin
        // Register state assumed by the table: X0=10, X1=15, X3=10.
        vecs[0]  = '{"and",      0,1,0,1,0, 5'b00000, 5'd1, 5'd0, 64'hA,   64'd10};
        vecs[1]  = '{"xor",      0,1,0,1,0, 5'b00100, 5'd1, 5'd0, 64'hA,   64'd5};
        vecs[2]  = '{"or",       0,1,0,1,0, 5'b01100, 5'd1, 5'd0, 64'h30,  64'h3F};
        vecs[3]  = '{"shl",      0,1,0,1,0, 5'b10000, 5'd1, 5'd0, 64'd4,   64'd240};
        vecs[4]  = '{"shl_mask", 0,1,0,1,0, 5'b10000, 5'd1, 5'd0, 64'h44,  64'd240};
        vecs[5]  = '{"shl_63",   0,1,0,1,0, 5'b10000, 5'd1, 5'd0, 64'd63,  64'h8000_0000_0000_0000};
        vecs[6]  = '{"shr",      0,1,0,1,0, 5'b10100, 5'd1, 5'd0, 64'd2,   64'd3};
        vecs[7]  = '{"pass110",  0,1,0,1,0, 5'b11000, 5'd1, 5'd0, 64'd7,   64'd15};
        vecs[8]  = '{"pass111",  0,1,0,1,0, 5'b11100, 5'd1, 5'd0, 64'd7,   64'd15};
        vecs[9]  = '{"and_inv_a",0,1,0,1,0, 5'b00010, 5'd1, 5'd0, 64'hFF,  64'hF0};
        vecs[10] = '{"add_regb", 0,1,0,0,0, 5'b01000, 5'd0, 5'd1, 64'd99,  64'd25};
        vecs[11] = '{"sub_regb", 0,1,0,0,1, 5'b01001, 5'd1, 5'd3, 64'd99,  64'd5};
        vecs[12] = '{"addr_wrap",0,0,1,1,0, 5'b00000, 5'd1, 5'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd14};

        idle();
        reset_reg = 1;
        tick();
        reset_reg = 0;
        for (int i = 0; i < 8; i++) check($sformatf("reset_r%0d", i), 64'(rr[i]), 64'd0);

        // X0 = 0 | 10
        SA = 5'd31; k = 64'd10; B_Sel = 1; FS = 5'b01100; EN_ALU = 1; DA = 5'd0; w_reg = 1;
        #1;
        check("or_bus", data_bus, 64'd10);
        check("r0_before_edge", 64'(r0), 64'd0);
        tick();
        check("r0_write", 64'(r0), 64'd10);

        // X1 = X0 + 5
        SA = 5'd0; k = 64'd5; FS = 5'b01000; C0 = 0; DA = 5'd1;
        #1;
        check("add_bus", data_bus, 64'd15);
        tick();
        check("r1_write", 64'(r1), 64'd15);

        // Bus from register B
        EN_ALU = 0; EN_B = 1; SB = 5'd0; DA = 5'd3;
        tick();
        check("r3_from_b", 64'(r3), 64'd10);
        DA = 5'd31;
        tick();
        w_reg = 0; SB = 5'd31;
        #1;
        check("x31_zero", data_bus, 64'd0);

        // Subtraction boundaries
        EN_B = 0; EN_ALU = 1; FS = 5'b01001; C0 = 1; SA = 5'd1; k = 64'd15;
        #1;
        check("sub_zero", data_bus, 64'd0);
        k = 64'd16;
        #1;
        check("sub_wrap", data_bus, 64'hFFFF_FFFF_FFFF_FFFF);

        for (int i = 0; i < 13; i++) begin
            idle();
            EN_B = vecs[i].en_b; EN_ALU = vecs[i].en_alu; EN_ADDR_ALU = vecs[i].en_addr;
            B_Sel = vecs[i].b_sel; C0 = vecs[i].c0; FS = vecs[i].fs;
            SA = vecs[i].sa; SB = vecs[i].sb; k = vecs[i].k;
            #1;
            check(vecs[i].name, data_bus, vecs[i].exp_bus);
        end

        // RAM write of X1 at X0+8 = 18, then read it back into X4
        idle();
        EN_B = 1; SB = 5'd1; SA = 5'd0; k = 64'd8; ram_cs = 1; ram_write_en = 1;
        tick();
        EN_B = 0; ram_write_en = 0; ram_read_en = 1; DA = 5'd4; w_reg = 1;
        #1;
        check("ram_read_bus", data_bus, 64'd15);
        tick();
        check("r4_from_ram", 64'(r4), 64'd15);

        // No DUT driver: an external driver must own the bus cleanly
        idle();
        tb_en = 1; tb_drive = 64'hA5A5_1234_5A5A_C3C3;
        #1;
        check("bus_released", data_bus, 64'hA5A5_1234_5A5A_C3C3);
        ram_cs = 1; SA = 5'd0; k = 64'd8;
        #1;
        check("ram_cs_no_read", data_bus, 64'hA5A5_1234_5A5A_C3C3);

        // Reset beats a simultaneous write
        idle();
        EN_ALU = 1; SA = 5'd31; k = 64'h77; FS = 5'b01100; DA = 5'd2; w_reg = 1; reset_reg = 1;
        tick();
        reset_reg = 0; w_reg = 0;
        for (int i = 0; i < 8; i++) check($sformatf("reset_wr_r%0d", i), 64'(rr[i]), 64'd0);

        // RAM survives reset; X1 does not
        idle();
        SA = 5'd0; k = 64'd18; ram_cs = 1; ram_read_en = 1;
        #1;
        check("ram_kept", data_bus, 64'd15);
        idle();
        EN_B = 1; SB = 5'd1;
        #1;
        check("x1_cleared", data_bus, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_path_v1.md
DATA_PATH_V1 -- requirements
Module: dataPath_V1

Interface
REQ-001 The block SHALL have these parameters: none; all widths fixed (64-bit data, 32 registers, 5-bit selects).
REQ-002 The block SHALL have these ports, in this order:
- r0..r7  out  16 each  low 16 bits of registers X0..X7, continuously.
- data_bus  inout  64  shared tri-state bus.
- k  in  64  constant/immediate operand.
- FS  in  5  ALU function select.
- B_Sel  in  1  ALU B-operand select: 1 = k, 0 = register port B.
- EN_B, EN_ALU, EN_ADDR_ALU  in  1 each  bus drive enables: register B, ALU result, address adder.
- ram_cs, ram_write_en, ram_read_en  in  1 each  RAM select, write, read.
- w_reg  in  1  register-file write enable.
- reset_reg  in  1  reset.
- clock  in  1  clock.
- SA, SB, DA  in  5 each  read addresses A and B, write address.
- C0  in  1  ALU carry-in.
REQ-003 One clock domain on clock; reset_reg is synchronous and active-high.

Function
REQ-004 Register file: 32 x 64-bit; two combinational read ports (A = X[SA], B = X[SB]) and one write port; X31 always reads 0 and writes to it are ignored.
REQ-005 On rising clock with w_reg=1 and reset_reg=0, X[DA] SHALL load data_bus; the new value is visible on read ports and r0..r7 after that edge.
REQ-006 ALU operands: A = X[SA] (inverted when FS[1]=1); B = (B_Sel ? k : X[SB]), inverted when FS[0]=1.
REQ-007 FS[4:2] op: 000 AND, 001 XOR, 010 ADD (A+B+C0, 64-bit, carry out discarded, wraps modulo 2^64), 011 OR, 100 shift A left by B[5:0], 101 logical shift A right by B[5:0], 110/111 pass A. Subtraction = FS 01001 with C0=1.
REQ-008 Address adder: X[SA] + k, 64-bit wrap, combinational.
REQ-009 RAM: 256 x 64-bit, word address = address-adder bits [7:0].
- Write: rising clock with ram_cs=1 and ram_write_en=1 stores data_bus.
- Read: ram_cs=1 and ram_read_en=0 -> 1 drives the addressed word onto data_bus combinationally.
REQ-010 Bus drivers: EN_B -> X[SB], EN_ALU -> ALU result, EN_ADDR_ALU -> address adder, RAM read per REQ-009; a non-enabled driver SHALL be high-Z; with no driver the bus floats (Z).
REQ-011 At most one driver enabled at a time is the user's obligation; the block SHALL NOT arbitrate, and contention yields X on the bus.
REQ-012 Register write and RAM write in the same cycle are allowed; both capture the same data_bus value.
REQ-013 Read-during-write to the same register SHALL return the old value until the edge.

Reset
REQ-014 Rising clock with reset_reg=1 SHALL clear X0..X30 to 0 (r0..r7 = 0); reset overrides w_reg. RAM contents are not reset.
REQ-015 Reset asserted mid-sequence SHALL take effect at the next edge; combinational paths are unaffected.

Structure
REQ-016 A shared package SHALL hold FS opcode constants (AND, XOR, ADD, OR, SHL, SHR, PASS) and the width constants.
REQ-017 The register file SHALL be a sub-module, reg_file_32x64; the ALU, address adder, RAM and bus drivers sit in the top level.

Verification
REQ-018 Reset, then SA=31, k=10, B_Sel=1, FS=01100, EN_ALU=1, DA=0, w_reg=1, one edge -> r0=10.
REQ-019 Then SA=0, k=5, FS=01000, C0=0, DA=1, one edge -> r1=15.
REQ-020 Then EN_ALU=0, EN_B=1, SB=0, DA=3, one edge -> r3=10; DA=31 write -> X31 still reads 0.
REQ-021 FS=01001, C0=1, SA=1, k=15 -> data_bus 0; then k=16 -> 0xFFFF_FFFF_FFFF_FFFF.
REQ-022 EN_B=1 drives X1 to the bus with SA=0, k=8, ram_cs=1, ram_write_en=1, one edge; then EN_B=0, ram_read_en=1, DA=4, w_reg=1 -> r4=15; with all enables 0, data_bus = Z.
REQ-023 reset_reg=1 asserted together with w_reg=1 -> all r* = 0 after the edge.
